// File: rtl/jump_ctrl.sv
// Branch/jump resolution ahead of the program counter: turns decoder control-flow
// requests into a jump_en/target pair using a programmable target LUT and a return stack.
module jump_ctrl #(
  parameter int D = 10,
  parameter int L = 4,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  input  logic         br_en,
  input  logic         br_cond,
  input  logic         jmp_en,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic         rel,
  input  logic [L-1:0] lut_idx,
  input  logic         lut_we,
  input  logic [L-1:0] lut_waddr,
  input  logic [D-1:0] lut_wdata,
  output logic         jump_en,
  output logic [D-1:0] target,
  output logic         stack_full,
  output logic         stack_empty,
  output logic         err
);

  localparam int CW = $clog2(S + 1);
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  logic [D-1:0]  lut [2**L];
  logic [D-1:0]  stk [S];
  logic [CW-1:0] count;

  logic [D-1:0]  lut_e;
  logic [D-1:0]  lut_t;
  logic [D-1:0]  ret_addr;
  logic [SW-1:0] top_idx;
  logic [SW-1:0] push_idx;
  logic          do_push;
  logic          do_pop;
  logic          overflow;
  logic          underflow;

  assign stack_empty = (count == '0);
  assign stack_full  = (count == CW'(S));

  assign lut_e    = lut[lut_idx];
  assign lut_t    = rel ? (prog_ctr + lut_e) : lut_e;
  assign ret_addr = prog_ctr + D'(1);
  assign top_idx  = SW'(count - CW'(1));
  assign push_idx = SW'(count);

  // ret outranks call, so a push and a pop can never happen in the same cycle
  assign do_push   = call_en && !ret_en && !stack_full;
  assign do_pop    = ret_en && !stack_empty;
  assign overflow  = call_en && !ret_en && stack_full;
  assign underflow = ret_en && stack_empty;

  always_comb begin
    jump_en = 1'b0;
    target  = '0;
    if (reset) begin
      if (ret_en) begin
        if (!stack_empty) begin
          jump_en = 1'b1;
          target  = stk[top_idx];
        end
      end else if (call_en || jmp_en) begin
        jump_en = 1'b1;
        target  = lut_t;
      end else if (br_en) begin
        jump_en = br_cond;
        target  = lut_t;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2**L; i++) lut[i] <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (lut_we) lut[lut_waddr] <= lut_wdata;
      if (do_push)     count <= count + CW'(1);
      else if (do_pop) count <= count - CW'(1);
      if (overflow || underflow) err <= 1'b1;
    end
  end

  // Stack contents need no reset: count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset && do_push) stk[push_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed vector table from the test plan, then random
// traffic checked against a queue-based reference model.
module tb_jump_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] prog_ctr;
  logic       br_en, br_cond, jmp_en, call_en, ret_en, rel;
  logic [3:0] lut_idx;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [9:0] lut_wdata;
  logic       jump_en;
  logic [9:0] target;
  logic       stack_full, stack_empty, err;

  jump_ctrl #(.D(10), .L(4), .S(4)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr),
    .br_en(br_en), .br_cond(br_cond), .jmp_en(jmp_en),
    .call_en(call_en), .ret_en(ret_en), .rel(rel),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .jump_en(jump_en), .target(target),
    .stack_full(stack_full), .stack_empty(stack_empty), .err(err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [9:0] pc;
    logic       br, cond, jmp, call, ret, rel;
    logic [3:0] idx;
    logic       we;
    logic [3:0] waddr;
    logic [9:0] wdata;
    logic       e_jen;
    logic [9:0] e_tgt;
    logic       e_full, e_empty, e_err;
  } vec_t;

  vec_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [9:0] exp_q[$];
  logic [9:0] m_lut [16];
  logic       m_err;

  function automatic vec_t mk(input logic r, input int pc, input logic br, input logic cond,
                              input logic jmp, input logic call, input logic ret, input logic rl,
                              input int idx, input logic we, input int wa, input int wd,
                              input logic ejen, input int etgt, input logic efull,
                              input logic eempty, input logic eerr);
    vec_t v;
    v.rst_n = r; v.pc = 10'(pc); v.br = br; v.cond = cond; v.jmp = jmp;
    v.call = call; v.ret = ret; v.rel = rl; v.idx = 4'(idx); v.we = we;
    v.waddr = 4'(wa); v.wdata = 10'(wd); v.e_jen = ejen; v.e_tgt = 10'(etgt);
    v.e_full = efull; v.e_empty = eempty; v.e_err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    reset = v.rst_n; prog_ctr = v.pc; br_en = v.br; br_cond = v.cond;
    jmp_en = v.jmp; call_en = v.call; ret_en = v.ret; rel = v.rel;
    lut_idx = v.idx; lut_we = v.we; lut_waddr = v.waddr; lut_wdata = v.wdata;
  endtask

  // Model prediction from the rules: priority ret > call > jmp > br.
  function automatic vec_t predict(input vec_t v);
    vec_t e = v;
    logic [9:0] lt;
    lt = v.rel ? 10'((int'(v.pc) + int'(m_lut[v.idx])) % 1024) : m_lut[v.idx];
    e.e_jen = 1'b0; e.e_tgt = '0;
    if (v.rst_n) begin
      if (v.ret) begin
        if (exp_q.size() > 0) begin e.e_jen = 1'b1; e.e_tgt = exp_q[$]; end
      end else if (v.call || v.jmp) begin
        e.e_jen = 1'b1; e.e_tgt = lt;
      end else if (v.br) begin
        e.e_jen = v.cond; e.e_tgt = lt;
      end
    end
    e.e_full  = (exp_q.size() == 4);
    e.e_empty = (exp_q.size() == 0);
    e.e_err   = m_err;
    return e;
  endfunction

  task automatic model_edge(input vec_t v);
    if (!v.rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) m_lut[i] = '0;
      m_err = 1'b0;
    end else begin
      if (v.ret) begin
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        else m_err = 1'b1;
      end else if (v.call) begin
        if (exp_q.size() < 4) exp_q.push_back(10'((int'(v.pc) + 1) % 1024));
        else m_err = 1'b1;
      end
      if (v.we) m_lut[v.waddr] = v.wdata;
    end
  endtask

  task automatic compare(input string tag, input vec_t e);
    check({tag, ".jump_en"},     int'(jump_en),     int'(e.e_jen));
    check({tag, ".target"},      int'(target),      int'(e.e_tgt));
    check({tag, ".stack_full"},  int'(stack_full),  int'(e.e_full));
    check({tag, ".stack_empty"}, int'(stack_empty), int'(e.e_empty));
    check({tag, ".err"},         int'(err),         int'(e.e_err));
  endtask

  // one cycle: drive at negedge, sample mid-low-phase, then take the edge
  task automatic step(input vec_t v, input bit use_table, input bit do_check, input string tag);
    vec_t e;
    @(negedge clk);
    drive(v);
    #2;
    e = use_table ? v : predict(v);
    if (do_check) compare(tag, e);
    @(posedge clk);
    model_edge(v);
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(idle);
    m_err = 1'b0;
    for (int i = 0; i < 16; i++) m_lut[i] = '0;

    //       r  pc     br c jmp cl rt rl idx we wa  wd      jen tgt    fu em er
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0, 1, 3, 'h120, 0, 0,     0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 1, 0, 0, 0, 3, 0, 0, 0,     1, 'h120, 0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0, 1, 5, 'h3FE, 0, 0,     0, 1, 0));
    tbl.push_back(mk(1, 'h005, 1, 1, 0, 0, 0, 1, 5, 0, 0, 0,     1, 'h003, 0, 1, 0));
    tbl.push_back(mk(1, 'h005, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,     0, 'h003, 0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0, 1, 7, 'h002, 0, 0,     0, 1, 0));
    tbl.push_back(mk(1, 'h3FF, 0, 0, 1, 0, 0, 1, 7, 0, 0, 0,     1, 'h001, 0, 1, 0));
    // write and read the same index in one cycle: old entry, then new
    tbl.push_back(mk(1, 0,     0, 0, 1, 0, 0, 0, 4, 1, 4, 'h3AA, 1, 0,     0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 1, 0, 0, 0, 4, 0, 0, 0,     1, 'h3AA, 0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0, 1, 1, 'h100, 0, 0,     0, 1, 0));
    // nested calls to fill the stack, overflow, then unwind
    tbl.push_back(mk(1, 10,    0, 0, 0, 1, 0, 0, 1, 0, 0, 0,     1, 'h100, 0, 1, 0));
    tbl.push_back(mk(1, 20,    0, 0, 0, 1, 0, 0, 1, 0, 0, 0,     1, 'h100, 0, 0, 0));
    tbl.push_back(mk(1, 30,    0, 0, 0, 1, 0, 0, 1, 0, 0, 0,     1, 'h100, 0, 0, 0));
    tbl.push_back(mk(1, 40,    0, 0, 0, 1, 0, 0, 1, 0, 0, 0,     1, 'h100, 0, 0, 0));
    tbl.push_back(mk(1, 50,    0, 0, 0, 1, 0, 0, 1, 0, 0, 0,     1, 'h100, 1, 0, 0));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0,     1, 41,    1, 0, 1));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0,     1, 31,    0, 0, 1));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0,     1, 21,    0, 0, 1));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0,     1, 11,    0, 0, 1));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0,     0, 0,     0, 1, 1));
    tbl.push_back(mk(1, 60,    0, 0, 0, 1, 1, 0, 1, 0, 0, 0,     0, 0,     0, 1, 1));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0,     0, 1, 1));
    // reset with live stack entries and a fresh LUT write
    tbl.push_back(mk(1, 100,   0, 0, 0, 1, 0, 0, 1, 0, 0, 0,     1, 'h100, 0, 1, 1));
    tbl.push_back(mk(1, 200,   0, 0, 0, 1, 0, 0, 1, 0, 0, 0,     1, 'h100, 0, 0, 1));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0, 1, 0, 'h155, 0, 0,     0, 0, 1));
    tbl.push_back(mk(0, 0,     0, 0, 1, 0, 0, 0, 0, 1, 2, 'h077, 0, 0,     0, 0, 1));
    tbl.push_back(mk(1, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0, 0,     1, 0,     0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 1, 0, 0, 0, 2, 0, 0, 0,     1, 0,     0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0,     0, 0,     0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0,     0, 1, 1));

    // initial reset: DUT state is unknown before this edge, so nothing is checked
    v = idle; v.rst_n = 1'b0;
    step(v, 1'b0, 1'b0, "init");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], 1'b1, 1'b1, $sformatf("vec%0d", i));

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      v.rst_n = ($urandom_range(0, 59) != 0);
      v.pc    = 10'($urandom_range(0, 1023));
      v.br    = ($urandom_range(0, 3) == 0);
      v.cond  = 1'($urandom);
      v.jmp   = ($urandom_range(0, 5) == 0);
      v.call  = ($urandom_range(0, 3) == 0);
      v.ret   = ($urandom_range(0, 3) == 0);
      v.rel   = 1'($urandom);
      v.idx   = 4'($urandom_range(0, 15));
      v.we    = ($urandom_range(0, 2) == 0);
      v.waddr = 4'($urandom_range(0, 15));
      v.wdata = 10'($urandom_range(0, 1023));
      step(v, 1'b0, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
